// File: rtl/avg_frame_sequencer_if.sv
// Signal bundle between the frame sequencer, its sample/result streams and the HLS averaging block.
// The master view belongs to the sequencer; the slave view belongs to whatever surrounds it.
interface avg_frame_sequencer_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [7:0] num_cfg;

    logic       hls_start;
    logic       hls_done;
    logic [7:0] hls_a;
    logic [7:0] hls_b;
    logic [7:0] hls_c;
    logic [7:0] hls_d;
    logic [7:0] hls_e;
    logic [7:0] hls_f;
    logic [7:0] hls_g;
    logic [7:0] hls_h;
    logic [7:0] hls_num;
    logic [7:0] hls_avg;

    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_avg;
    logic       out_div0;
    logic [15:0] frames_done;

    modport master (
        input  in_valid, in_data, num_cfg, hls_done, hls_avg, out_ready,
        output in_ready, hls_start, hls_a, hls_b, hls_c, hls_d, hls_e, hls_f, hls_g, hls_h,
               hls_num, out_valid, out_avg, out_div0, frames_done
    );

    modport slave (
        output in_valid, in_data, num_cfg, hls_done, hls_avg, out_ready,
        input  in_ready, hls_start, hls_a, hls_b, hls_c, hls_d, hls_e, hls_f, hls_g, hls_h,
               hls_num, out_valid, out_avg, out_div0, frames_done
    );
endinterface

// File: rtl/avg_frame_sequencer.sv
// Packs eight streamed samples into frozen operands, launches one HLS average and
// presents the result on a valid/ready output; a zero divisor bypasses the HLS block.
module avg_frame_sequencer #(
    parameter int HLS_LATENCY = 10,
    parameter int FRAME_LEN   = 8
) (
    input logic                   Clk,
    input logic                   Rst,
    avg_frame_sequencer_if.master bus
);
    localparam int IW = $clog2(FRAME_LEN);
    localparam int CW = $clog2(HLS_LATENCY + 1);
    localparam logic [IW-1:0] LAST_SLOT = IW'(FRAME_LEN - 1);
    localparam logic [CW-1:0] LAT       = CW'(HLS_LATENCY);

    typedef enum logic [1:0] {FILL, LAUNCH, WAIT, HOLD} state_t;

    state_t        state;
    state_t        state_next;
    logic [7:0]    slot [FRAME_LEN];
    logic [IW-1:0] idx;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic [7:0]    num_q;
    logic [7:0]    avg_q;
    logic          div0_q;
    logic [15:0]   frames_q;
    logic          done_prev;
    logic          done_edge;
    logic          alive;
    logic          accept;
    logic          launch;
    logic          skip;
    logic          capture;
    logic          retire;

    assign bus.hls_a       = slot[0];
    assign bus.hls_b       = slot[1];
    assign bus.hls_c       = slot[2];
    assign bus.hls_d       = slot[3];
    assign bus.hls_e       = slot[4];
    assign bus.hls_f       = slot[5];
    assign bus.hls_g       = slot[6];
    assign bus.hls_h       = slot[7];
    assign bus.hls_num     = num_q;
    assign bus.out_avg     = avg_q;
    assign bus.out_div0    = div0_q;
    assign bus.frames_done = frames_q;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state <= FILL;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = state;
        bus.in_ready  = 1'b0;
        bus.hls_start = 1'b0;
        bus.out_valid = 1'b0;
        accept        = 1'b0;
        launch        = 1'b0;
        skip          = 1'b0;
        capture       = 1'b0;
        retire        = 1'b0;
        cnt_next      = cnt + CW'(1);
        done_edge     = bus.hls_done && !done_prev;

        case (state)
            FILL: begin
                bus.in_ready = alive;
                if (alive && bus.in_valid) begin
                    accept = 1'b1;
                    if (idx == LAST_SLOT) begin
                        state_next = LAUNCH;
                    end
                end
            end
            LAUNCH: begin
                if (num_q == 8'd0) begin
                    skip       = 1'b1;
                    state_next = HOLD;
                end else begin
                    launch        = 1'b1;
                    bus.hls_start = 1'b1;
                    state_next    = WAIT;
                end
            end
            WAIT: begin
                // An edge is required because Done stays high after the first computation.
                if (done_edge || (cnt_next == LAT)) begin
                    capture    = 1'b1;
                    state_next = HOLD;
                end
            end
            HOLD: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    retire     = 1'b1;
                    state_next = FILL;
                end
            end
            default: state_next = FILL;
        endcase
    end

    // alive keeps in_ready low until the first clock after reset release.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            for (int i = 0; i < FRAME_LEN; i++) begin
                slot[i] <= '0;
            end
            idx       <= '0;
            cnt       <= '0;
            num_q     <= '0;
            avg_q     <= '0;
            div0_q    <= 1'b0;
            frames_q  <= '0;
            done_prev <= 1'b0;
            alive     <= 1'b0;
        end else begin
            alive     <= 1'b1;
            done_prev <= bus.hls_done;
            if (accept) begin
                slot[idx] <= bus.in_data;
                if (idx == '0) begin
                    num_q <= bus.num_cfg;
                end
                idx <= (idx == LAST_SLOT) ? '0 : idx + IW'(1);
            end
            if (launch) begin
                cnt <= '0;
            end else if (state == WAIT) begin
                cnt <= cnt_next;
            end
            if (skip) begin
                avg_q  <= 8'd0;
                div0_q <= 1'b1;
            end else if (capture) begin
                avg_q  <= bus.hls_avg;
                div0_q <= 1'b0;
            end
            if (retire) begin
                frames_q <= frames_q + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_avg_frame_sequencer.sv
// Randomized bench for avg_frame_sequencer with a behavioural HLS averaging block
// and a frame-level reference model of the expected result, latency and counters.
module tb_avg_frame_sequencer;
    localparam int L = 10;

    logic Clk = 1'b0;
    logic Rst = 1'b1;
    always #5 Clk = ~Clk;

    avg_frame_sequencer_if bus ();

    avg_frame_sequencer #(.HLS_LATENCY(L), .FRAME_LEN(8)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    int          testCount = 0;
    int          failCount = 0;
    logic [15:0] expFrames = '0;

    // Behavioural HLS block: garbage result until done, reads operands late, Done sticky.
    logic [7:0] hlsAvg   = 8'h00;
    logic       hlsDone  = 1'b0;
    bit         hlsBusy  = 1'b0;
    bit         hlsRearm = 1'b0;
    int         hlsCnt   = 0;
    int         hlsLat   = 3;

    assign bus.hls_done = hlsDone;
    assign bus.hls_avg  = hlsAvg;

    always @(posedge Clk) begin
        int sum;
        if (bus.hls_start) begin
            hlsBusy <= 1'b1;
            hlsCnt  <= 1;
            hlsAvg  <= 8'($urandom);
            if (hlsRearm) hlsDone <= 1'b0;
        end else if (hlsBusy) begin
            if (hlsCnt == hlsLat) begin
                sum = int'($signed(bus.hls_a)) + int'($signed(bus.hls_b)) + int'($signed(bus.hls_c))
                    + int'($signed(bus.hls_d)) + int'($signed(bus.hls_e)) + int'($signed(bus.hls_f))
                    + int'($signed(bus.hls_g)) + int'($signed(bus.hls_h));
                hlsAvg  <= 8'(sum / int'($signed(bus.hls_num)));
                hlsDone <= 1'b1;
                hlsBusy <= 1'b0;
            end
            hlsCnt <= hlsCnt + 1;
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        testCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [8:0] refAvg(input logic [7:0] s [8], input logic [7:0] n);
        int sum = 0;
        if (n == 8'd0) return {1'b1, 8'h00};
        foreach (s[i]) sum += int'($signed(s[i]));
        return {1'b0, 8'(sum / int'($signed(n)))};
    endfunction

    function automatic logic [63:0] opsNow();
        return {bus.hls_a, bus.hls_b, bus.hls_c, bus.hls_d, bus.hls_e, bus.hls_f, bus.hls_g, bus.hls_h};
    endfunction

    task automatic pulseReset();
        #3 Rst = 1'b1;
        #1;
        checkOutput("rst_out_valid", bus.out_valid, 0);
        checkOutput("rst_in_ready", bus.in_ready, 0);
        checkOutput("rst_hls_start", bus.hls_start, 0);
        checkOutput("rst_out_div0", bus.out_div0, 0);
        checkOutput("rst_out_avg", bus.out_avg, 0);
        checkOutput("rst_frames_done", bus.frames_done, 0);
        checkOutput("rst_hls_num", bus.hls_num, 0);
        checkOutput("rst_ops", opsNow(), 0);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        for (int k = 0; k < 40 && hlsBusy; k++) @(posedge Clk);
        @(negedge Clk);
        Rst = 1'b0;
        #1 checkOutput("release_in_ready_low", bus.in_ready, 0);
        @(posedge Clk);
        #1 checkOutput("release_in_ready_high", bus.in_ready, 1);
        expFrames = '0;
    endtask

    // abortAt: 0 none, 1 reset after 3 samples, 2 reset in WAIT, 3 reset in HOLD.
    task automatic applyStimulus(input logic [7:0] s [8], input logic [7:0] n, input bit rearm,
                                 input int holdCycles, input bit driveHold, input int abortAt);
        logic [8:0]  expRes;
        logic [63:0] expOps;
        int          expLat;
        int          c;
        int          guard;
        bit          ok;
        bit          edgeExp;

        hlsRearm = rearm;
        hlsLat   = $urandom_range(1, 6);
        expOps   = {s[0], s[1], s[2], s[3], s[4], s[5], s[6], s[7]};
        expRes   = refAvg(s, n);

        for (int i = 0; i < 8; i++) begin
            if (abortAt == 1 && i == 3) begin
                pulseReset();
                return;
            end
            bus.in_data = s[i];
            bus.num_cfg = (i == 0) ? n : 8'($urandom);
            ok    = 1'b0;
            guard = 0;
            while (!ok && guard < 200) begin
                bus.in_valid = ($urandom_range(0, 99) >= 30);
                ok = bus.in_valid && bus.in_ready;
                @(posedge Clk);
                #1;
                guard++;
            end
            if (!ok) begin
                checkOutput("accept_timeout", 64'(ok), 1);
                return;
            end
        end
        bus.in_valid = driveHold;
        bus.in_data  = 8'hA5;
        bus.num_cfg  = 8'($urandom);

        edgeExp = rearm || !hlsDone;
        if (n == 8'd0) expLat = 1;
        else if (edgeExp) expLat = ((hlsLat + 1 < L) ? hlsLat + 1 : L) + 1;
        else expLat = L + 1;

        checkOutput("launch_hls_start", bus.hls_start, (n != 8'd0));
        checkOutput("launch_in_ready", bus.in_ready, 0);
        checkOutput("launch_hls_num", bus.hls_num, n);
        checkOutput("launch_ops", opsNow(), expOps);

        c = 0;
        while (c < 40) begin
            bus.out_ready = 1'($urandom_range(0, 1));
            @(posedge Clk);
            #1;
            c++;
            if (bus.out_valid) break;
            checkOutput("wait_ops", opsNow(), expOps);
            checkOutput("wait_hls_num", bus.hls_num, n);
            checkOutput("wait_in_ready", bus.in_ready, 0);
            checkOutput("wait_hls_start", bus.hls_start, 0);
            if (abortAt == 2 && c == 3) begin
                pulseReset();
                return;
            end
        end
        bus.out_ready = 1'b0;
        checkOutput("result_latency", 64'(c), 64'(expLat));
        if (!bus.out_valid) return;
        checkOutput("out_avg", bus.out_avg, expRes[7:0]);
        checkOutput("out_div0", bus.out_div0, expRes[8]);
        if (abortAt == 3) begin
            pulseReset();
            return;
        end

        for (int h = 0; h < holdCycles; h++) begin
            @(posedge Clk);
            #1;
            checkOutput("hold_out_valid", bus.out_valid, 1);
            checkOutput("hold_out_avg", bus.out_avg, expRes[7:0]);
            checkOutput("hold_in_ready", bus.in_ready, 0);
        end

        bus.out_ready = 1'b1;
        @(posedge Clk);
        #1;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        expFrames     = expFrames + 16'd1;
        checkOutput("retire_out_valid", bus.out_valid, 0);
        checkOutput("frames_done", bus.frames_done, expFrames);
        checkOutput("retire_in_ready", bus.in_ready, 1);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no finish expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] s [8];
        logic [7:0] n;

        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.num_cfg   = 8'h00;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        checkOutput("reset_in_ready", bus.in_ready, 0);
        checkOutput("reset_out_valid", bus.out_valid, 0);
        checkOutput("reset_hls_start", bus.hls_start, 0);
        checkOutput("reset_frames_done", bus.frames_done, 0);
        checkOutput("reset_out_div0", bus.out_div0, 0);
        checkOutput("reset_ops", opsNow(), 0);
        @(negedge Clk);
        Rst = 1'b0;
        @(posedge Clk);
        #1 checkOutput("first_in_ready", bus.in_ready, 1);

        $display("[TB] frame 1..8 / 8");
        s = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
        applyStimulus(s, 8'd8, 1'b0, 0, 1'b0, 0);

        $display("[TB] eight -10 samples / 3");
        foreach (s[i]) s[i] = 8'hF6;
        applyStimulus(s, 8'd3, 1'b1, 0, 1'b0, 0);

        $display("[TB] divide by zero");
        foreach (s[i]) s[i] = 8'($urandom);
        applyStimulus(s, 8'd0, 1'b1, 0, 1'b0, 0);

        $display("[TB] back-to-back with sticky Done");
        for (int f = 0; f < 2; f++) begin
            foreach (s[i]) s[i] = 8'($urandom);
            applyStimulus(s, 8'($urandom_range(1, 127)), 1'b0, 0, 1'b0, 0);
        end

        $display("[TB] long HOLD with in_valid driven");
        foreach (s[i]) s[i] = 8'($urandom);
        applyStimulus(s, 8'd5, 1'b1, 20, 1'b1, 0);
        foreach (s[i]) s[i] = 8'($urandom);
        applyStimulus(s, 8'hFD, 1'b1, 0, 1'b0, 0);

        $display("[TB] asynchronous reset in WAIT, HOLD and FILL");
        for (int a = 2; a >= 1; a--) begin
            foreach (s[i]) s[i] = 8'($urandom);
            applyStimulus(s, 8'd7, 1'b1, 0, 1'b0, a);
            foreach (s[i]) s[i] = 8'($urandom);
            applyStimulus(s, 8'd4, 1'b1, 1, 1'b0, 0);
        end
        foreach (s[i]) s[i] = 8'($urandom);
        applyStimulus(s, 8'd6, 1'b1, 0, 1'b0, 3);
        foreach (s[i]) s[i] = 8'($urandom);
        applyStimulus(s, 8'd2, 1'b0, 0, 1'b0, 0);

        $display("[TB] random frames");
        for (int f = 0; f < 8; f++) begin
            foreach (s[i]) s[i] = 8'($urandom);
            n = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
            applyStimulus(s, n, 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                          1'($urandom_range(0, 1)), 0);
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end
endmodule
